// File: rtl/motion_ctrl_sched.sv
// ============================================================================
// Module   : motion_ctrl_sched
// Brief    : Gameplay phase sequencer driving run/jump controls of the sprite
//            position block (countdown, speed ramp, charged jump, game-over).
// Revision : 1.0
// ============================================================================
`default_nettype none

module motion_ctrl_sched #(
    parameter int MIN_SPEED        = 2,
    parameter int MAX_SPEED        = 8,
    parameter int RAMP_FRAMES      = 120,
    parameter int JUMP_MIN         = 8,
    parameter int JUMP_MAX         = 20,
    parameter int CHARGE_DIV       = 4,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int ACK_FRAMES       = 4
) (
    input  logic        i_clk_pix,
    input  logic        i_rst_n,
    input  logic        i_frame,
    input  logic        i_btn_start,
    input  logic        i_btn_jump,
    input  logic        i_jumping,
    input  logic        i_collide,
    output logic        o_run,
    output logic [15:0] o_run_speed,
    output logic        o_jump,
    output logic [15:0] o_jump_height,
    output logic [2:0]  o_state,
    output logic [15:0] o_score
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_CHARGE    = 3'd3;
    localparam logic [2:0] S_LAUNCH    = 3'd4;
    localparam logic [2:0] S_AIR       = 3'd5;
    localparam logic [2:0] S_OVER      = 3'd6;

    localparam logic [15:0] MIN_SPEED_V = 16'(MIN_SPEED);
    localparam logic [15:0] MAX_SPEED_V = 16'(MAX_SPEED);
    localparam logic [15:0] RAMP_LAST   = 16'(RAMP_FRAMES - 1);
    localparam logic [15:0] JUMP_MIN_V  = 16'(JUMP_MIN);
    localparam logic [15:0] JUMP_MAX_V  = 16'(JUMP_MAX);
    localparam logic [15:0] CHARGE_LAST = 16'(CHARGE_DIV - 1);
    localparam logic [15:0] COUNT_LOAD  = 16'(COUNTDOWN_FRAMES);
    localparam logic [15:0] ACK_LAST    = 16'(ACK_FRAMES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic        start_q;
    logic        jump_q;
    logic [15:0] cnt;
    logic [15:0] ramp;
    logic [15:0] sub;
    logic [15:0] ack;
    logic [15:0] charge;
    logic [15:0] speed;
    logic [15:0] score;
    logic [15:0] height;
    logic        start_rise;
    logic        jump_rise;
    logic        running;
    logic [16:0] score_sum;

    assign start_rise = i_btn_start & ~start_q;
    assign jump_rise  = i_btn_jump & ~jump_q;
    assign running    = (state == S_RUN) || (state == S_CHARGE) ||
                        (state == S_LAUNCH) || (state == S_AIR);
    assign score_sum  = {1'b0, score} + {1'b0, speed};

    // State register
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; collision overrides every transition out of a running state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start_rise) state_nx = S_COUNTDOWN;
            S_COUNTDOWN: if (i_frame && cnt == 16'd1) state_nx = S_RUN;
            S_RUN:       if (jump_rise) state_nx = S_CHARGE;
            S_CHARGE:    if (!i_btn_jump) state_nx = S_LAUNCH;
            S_LAUNCH: begin
                if (i_jumping) begin
                    state_nx = S_AIR;
                end else if (i_frame && ack == ACK_LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_AIR:       if (!i_jumping) state_nx = S_RUN;
            S_OVER:      if (start_rise) state_nx = S_COUNTDOWN;
            default:     state_nx = S_IDLE;
        endcase
        if (running && i_collide) begin
            state_nx = S_OVER;
        end
    end

    // Outputs
    always_comb begin
        o_run         = running;
        o_jump        = (state == S_LAUNCH);
        o_state       = state;
        o_run_speed   = speed;
        o_jump_height = height;
        o_score       = score;
    end

    // Datapath: counters, speed ramp, score and jump charge
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            start_q <= 1'b0;
            jump_q  <= 1'b0;
            cnt     <= 16'd0;
            ramp    <= 16'd0;
            sub     <= 16'd0;
            ack     <= 16'd0;
            charge  <= JUMP_MIN_V;
            speed   <= MIN_SPEED_V;
            score   <= 16'd0;
            height  <= JUMP_MIN_V;
        end else begin
            start_q <= i_btn_start;
            jump_q  <= i_btn_jump;

            if ((state == S_IDLE || state == S_OVER) && start_rise) begin
                cnt   <= COUNT_LOAD;
                score <= 16'd0;
                speed <= MIN_SPEED_V;
                ramp  <= 16'd0;
            end

            if (state == S_COUNTDOWN && i_frame) begin
                cnt <= cnt - 16'd1;
            end

            // Score takes the pre-increment speed when a ramp step lands on the same frame
            if (running && !i_collide && i_frame) begin
                score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                if (ramp == RAMP_LAST) begin
                    ramp <= 16'd0;
                    if (speed < MAX_SPEED_V) begin
                        speed <= speed + 16'd1;
                    end
                end else begin
                    ramp <= ramp + 16'd1;
                end
            end

            if (state == S_RUN && jump_rise && !i_collide) begin
                charge <= JUMP_MIN_V;
                sub    <= 16'd0;
            end

            if (state == S_CHARGE && !i_collide) begin
                if (!i_btn_jump) begin
                    height <= charge;
                end else if (i_frame) begin
                    if (sub == CHARGE_LAST) begin
                        sub <= 16'd0;
                        if (charge < JUMP_MAX_V) begin
                            charge <= charge + 16'd1;
                        end
                    end else begin
                        sub <= sub + 16'd1;
                    end
                end
            end

            if (state != S_LAUNCH) begin
                ack <= 16'd0;
            end else if (i_frame) begin
                ack <= ack + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_motion_ctrl_sched.sv
// ============================================================================
// Module   : tb_motion_ctrl_sched
// Brief    : Self-checking bench for motion_ctrl_sched with a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_motion_ctrl_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_jump = 1'b0;
    logic        jumping = 1'b0;
    logic        collide = 1'b0;
    logic        run;
    logic [15:0] run_speed;
    logic        jump;
    logic [15:0] jump_height;
    logic [2:0]  state;
    logic [15:0] score;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level reference model of speed ramp and score
    bit          m_running = 1'b0;
    int          m_speed = 2;
    int          m_ramp = 0;
    int          m_score = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    logic [15:0] saved_score;
    logic [15:0] saved_speed;

    motion_ctrl_sched dut (
        .i_clk_pix     (clk),
        .i_rst_n       (rst_n),
        .i_frame       (frame),
        .i_btn_start   (btn_start),
        .i_btn_jump    (btn_jump),
        .i_jumping     (jumping),
        .i_collide     (collide),
        .o_run         (run),
        .o_run_speed   (run_speed),
        .o_jump        (jump),
        .o_jump_height (jump_height),
        .o_state       (state),
        .o_score       (score)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        frame = 1'b1;
        if (m_running) begin
            m_score = (m_score + m_speed > 65535) ? 65535 : m_score + m_speed;
            if (m_ramp == 119) begin
                m_ramp = 0;
                if (m_speed < 8) m_speed++;
            end else begin
                m_ramp++;
            end
        end
        tick();
        frame = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++; if (state !== 3'd0) $display("FAIL %s_state: got %0d expected 0", tag, state); else n_pass++;
        n_checks++; if (run !== 1'b0) $display("FAIL %s_run: got %0b expected 0", tag, run); else n_pass++;
        n_checks++; if (run_speed !== 16'd2) $display("FAIL %s_speed: got %0d expected 2", tag, run_speed); else n_pass++;
        n_checks++; if (jump !== 1'b0) $display("FAIL %s_jump: got %0b expected 0", tag, jump); else n_pass++;
        n_checks++; if (jump_height !== 16'd8) $display("FAIL %s_height: got %0d expected 8", tag, jump_height); else n_pass++;
        n_checks++; if (score !== 16'd0) $display("FAIL %s_score: got %0d expected 0", tag, score); else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_countdown();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        n_checks++; if (state !== 3'd1) $display("FAIL cd_enter: got %0d expected 1", state); else n_pass++;
        repeat (179) do_frame();
        n_checks++; if (state !== 3'd1) $display("FAIL cd_hold179: got %0d expected 1", state); else n_pass++;
        do_frame();
        n_checks++; if (state !== 3'd2) $display("FAIL cd_run_state: got %0d expected 2", state); else n_pass++;
        n_checks++; if (run !== 1'b1) $display("FAIL cd_run: got %0b expected 1", run); else n_pass++;
        n_checks++; if (run_speed !== 16'd2) $display("FAIL cd_speed: got %0d expected 2", run_speed); else n_pass++;
        n_checks++; if (score !== 16'd0) $display("FAIL cd_score: got %0d expected 0", score); else n_pass++;
        m_running = 1'b1; m_speed = 2; m_ramp = 0; m_score = 0;
    endtask

    task automatic test_ramp();
        repeat (120) do_frame();
        exp_q.push_back(16'd3);
        exp_q.push_back(16'(m_score));
        exp = exp_q.pop_front();
        n_checks++; if (run_speed !== exp) $display("FAIL ramp_first: got %0d expected %0d", run_speed, exp); else n_pass++;
        exp = exp_q.pop_front();
        n_checks++; if (score !== exp) $display("FAIL ramp_score1: got %0d expected %0d", score, exp); else n_pass++;
        repeat (720) do_frame();
        exp_q.push_back(16'd8);
        exp_q.push_back(16'(m_score));
        exp = exp_q.pop_front();
        n_checks++; if (run_speed !== exp) $display("FAIL ramp_sat: got %0d expected %0d", run_speed, exp); else n_pass++;
        exp = exp_q.pop_front();
        n_checks++; if (score !== exp) $display("FAIL ramp_score2: got %0d expected %0d", score, exp); else n_pass++;
    endtask

    task automatic test_jump_tap();
        btn_jump = 1'b1;
        tick();
        n_checks++; if (state !== 3'd3) $display("FAIL tap_charge: got %0d expected 3", state); else n_pass++;
        repeat (3) do_frame();
        btn_jump = 1'b0;
        exp_q.push_back(16'd8);
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (jump_height !== exp) $display("FAIL tap_height: got %0d expected %0d", jump_height, exp); else n_pass++;
        n_checks++; if (jump !== 1'b1 || state !== 3'd4) $display("FAIL tap_launch: got jump=%0b state=%0d expected 1/4", jump, state); else n_pass++;
        tick();
        n_checks++; if (jump !== 1'b1 || state !== 3'd4) $display("FAIL tap_wait_ack: got jump=%0b state=%0d expected 1/4", jump, state); else n_pass++;
        jumping = 1'b1;
        tick();
        n_checks++; if (jump !== 1'b0 || state !== 3'd5) $display("FAIL tap_air: got jump=%0b state=%0d expected 0/5", jump, state); else n_pass++;
        btn_jump = 1'b1;
        tick();
        jumping = 1'b0;
        tick();
        n_checks++; if (state !== 3'd2) $display("FAIL tap_land: got %0d expected 2", state); else n_pass++;
        repeat (3) do_frame();
        tick();
        n_checks++; if (state !== 3'd2 || jump !== 1'b0) $display("FAIL tap_held_retrigger: got state=%0d jump=%0b expected 2/0", state, jump); else n_pass++;
        btn_jump = 1'b0;
        tick();
    endtask

    task automatic test_charge_levels();
        int held[2]  = '{12, 100};
        int height[2] = '{11, 20};
        for (int i = 0; i < 2; i++) begin
            btn_jump = 1'b1;
            tick();
            n_checks++; if (state !== 3'd3) $display("FAIL chg%0d_state: got %0d expected 3", i, state); else n_pass++;
            repeat (held[i]) do_frame();
            btn_jump = 1'b0;
            exp_q.push_back(16'(height[i]));
            tick();
            exp = exp_q.pop_front();
            n_checks++; if (jump_height !== exp) $display("FAIL chg%0d_height: got %0d expected %0d", i, jump_height, exp); else n_pass++;
            n_checks++; if (jump !== 1'b1) $display("FAIL chg%0d_jump: got %0b expected 1", i, jump); else n_pass++;
            jumping = 1'b1;
            tick();
            n_checks++; if (state !== 3'd5 || jump_height !== exp) $display("FAIL chg%0d_air: got state=%0d height=%0d expected 5/%0d", i, state, jump_height, exp); else n_pass++;
            jumping = 1'b0;
            tick();
            n_checks++; if (state !== 3'd2) $display("FAIL chg%0d_land: got %0d expected 2", i, state); else n_pass++;
        end
    endtask

    task automatic test_ack_timeout();
        btn_jump = 1'b1;
        tick();
        btn_jump = 1'b0;
        tick();
        n_checks++; if (state !== 3'd4 || jump_height !== 16'd8) $display("FAIL ack_launch: got state=%0d height=%0d expected 4/8", state, jump_height); else n_pass++;
        repeat (3) do_frame();
        n_checks++; if (state !== 3'd4 || jump !== 1'b1) $display("FAIL ack_pending: got state=%0d jump=%0b expected 4/1", state, jump); else n_pass++;
        do_frame();
        n_checks++; if (state !== 3'd2) $display("FAIL ack_drop_state: got %0d expected 2", state); else n_pass++;
        n_checks++; if (jump !== 1'b0) $display("FAIL ack_drop_jump: got %0b expected 0", jump); else n_pass++;
    endtask

    task automatic test_collide();
        btn_jump = 1'b1;
        tick();
        repeat (2) do_frame();
        exp_q.push_back(16'(m_score));
        frame = 1'b1;
        collide = 1'b1;
        tick();
        frame = 1'b0;
        m_running = 1'b0;
        exp = exp_q.pop_front();
        n_checks++; if (state !== 3'd6) $display("FAIL col_state: got %0d expected 6", state); else n_pass++;
        n_checks++; if (run !== 1'b0 || jump !== 1'b0) $display("FAIL col_outputs: got run=%0b jump=%0b expected 0/0", run, jump); else n_pass++;
        n_checks++; if (score !== exp) $display("FAIL col_score: got %0d expected %0d", score, exp); else n_pass++;
        saved_speed = 16'(m_speed);
        repeat (5) do_frame();
        collide = 1'b0;
        btn_jump = 1'b0;
        repeat (3) do_frame();
        n_checks++; if (score !== exp || run_speed !== saved_speed) $display("FAIL col_frozen: got score=%0d speed=%0d expected %0d/%0d", score, run_speed, exp, saved_speed); else n_pass++;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        n_checks++; if (state !== 3'd1) $display("FAIL col_restart: got %0d expected 1", state); else n_pass++;
        n_checks++; if (score !== 16'd0 || run_speed !== 16'd2) $display("FAIL col_restart_vals: got score=%0d speed=%0d expected 0/2", score, run_speed); else n_pass++;
    endtask

    task automatic test_reset_mid_air();
        repeat (180) do_frame();
        n_checks++; if (state !== 3'd2) $display("FAIL rst_run: got %0d expected 2", state); else n_pass++;
        btn_jump = 1'b1;
        tick();
        repeat (5) do_frame();
        btn_jump = 1'b0;
        tick();
        jumping = 1'b1;
        tick();
        n_checks++; if (state !== 3'd5 || jump_height !== 16'd9) $display("FAIL rst_air: got state=%0d height=%0d expected 5/9", state, jump_height); else n_pass++;
        saved_score = score;
        n_checks++; if (saved_score === 16'd0) $display("FAIL rst_score_nonzero: got %0d expected nonzero", saved_score); else n_pass++;
        rst_n = 1'b0;
        tick();
        check_reset_values("rst_air");
        jumping = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_ramp();
        test_jump_tap();
        test_charge_levels();
        test_ack_timeout();
        test_collide();
        test_reset_mid_air();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
